// File: rtl/fifo_arb_pkg.sv
// -----------------------------------------------------------------------------
// fifo_arb_pkg
//   Shared types and helpers for the FIFO write-port arbiter.
//   - arb_state_t : arbiter state (IDLE between grants, GRANT while owned)
//   - cnt_width() : beat-counter width for a given burst length
//   - CNT_W       : beat-counter width for the default burst length
//   - rr_next()   : round-robin successor of a producer index
// -----------------------------------------------------------------------------
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    localparam int BURST_DEFAULT = 4;

    // One extra bit so the counter can hold the value BURST itself.
    function automatic int cnt_width(input int burst);
        return $clog2(burst) + 1;
    endfunction

    localparam int CNT_W = cnt_width(BURST_DEFAULT);

    // Index after ptr, wrapping from n-1 back to 0.
    function automatic int rr_next(input int ptr, input int n);
        return (ptr + 1 >= n) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
//   Combinational round-robin picker: first set bit of req at or after ptr,
//   searching cyclically.
//   Ports:
//     req         in   NREQ   request vector
//     ptr         in   PTR_W  highest-priority index
//     pick_onehot out  NREQ   one-hot winner (0 when pick_valid is 0)
//     pick_idx    out  PTR_W  index of the winner
//     pick_valid  out  1      at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic [NREQ-1:0]  req,
    input  logic [PTR_W-1:0] ptr,
    output logic [NREQ-1:0]  pick_onehot,
    output logic [PTR_W-1:0] pick_idx,
    output logic             pick_valid
);

    logic [2*NREQ-1:0] req_dbl;
    logic [NREQ-1:0]   req_rot;
    logic [PTR_W-1:0]  offset;
    logic [PTR_W:0]    idx_sum;
    logic              found;

    always_comb begin
        // NOTE: every variable driven here gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        offset      = '0;
        found       = 1'b0;
        idx_sum     = '0;
        pick_idx    = '0;
        pick_onehot = '0;

        // Rotating the doubled vector right by ptr puts ptr at bit 0, so a
        // plain lowest-bit-first search becomes a cyclic search from ptr.
        req_dbl    = {req, req} >> ptr;
        req_rot    = req_dbl[NREQ-1:0];
        pick_valid = |req;

        for (int i = 0; i < NREQ; i++) begin
            if (req_rot[i] && !found) begin
                offset = PTR_W'(i);
                found  = 1'b1;
            end
        end

        // Undo the rotation: winner = (ptr + offset) mod NREQ.
        idx_sum = {1'b0, ptr} + {1'b0, offset};
        if (idx_sum >= (PTR_W + 1)'(NREQ)) begin
            idx_sum = idx_sum - (PTR_W + 1)'(NREQ);
        end
        pick_idx = idx_sum[PTR_W-1:0];

        if (pick_valid) begin
            pick_onehot = NREQ'(1) << pick_idx;
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// fifo_wr_arbiter
//   Round-robin arbiter sharing one FIFO write port among NREQ producers.
//   A producer holds the grant for up to BURST words or until it marks the
//   end of its packet; every release passes through one IDLE cycle.
//   Ports:
//     CLOCK          in   1            rising-edge clock
//     RESET          in   1            synchronous reset, active high
//     REQ            in   NREQ         producer i has a valid word
//     REQ_DATA       in   NREQ*WIDTH   producer words, slice i = [i*WIDTH +: WIDTH]
//     REQ_LAST       in   NREQ         producer i's word ends its packet
//     GNT            out  NREQ         one-hot grant (registered)
//     ACK            out  NREQ         word accepted this cycle (combinational)
//     FIFO_DATA_IN   out  WIDTH        FIFO data (registered)
//     FIFO_WRITE     out  1            FIFO write strobe (registered)
//     FIFO_USE_DW    in   clog2(DEPTH)+1  FIFO fill count
//     FIFO_F_FULL_N  in   1            FIFO full, active low
//     BUSY           out  1            a grant is held
//     OWNER          out  PTR_W        granted producer index, 0 when idle
// -----------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 32,
    parameter int NREQ  = 4,
    parameter int BURST = BURST_DEFAULT,
    localparam int UW    = $clog2(DEPTH) + 1,
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1
) (
    input  logic                  CLOCK,
    input  logic                  RESET,
    input  logic [NREQ-1:0]       REQ,
    input  logic [NREQ*WIDTH-1:0] REQ_DATA,
    input  logic [NREQ-1:0]       REQ_LAST,
    output logic [NREQ-1:0]       GNT,
    output logic [NREQ-1:0]       ACK,
    output logic [WIDTH-1:0]      FIFO_DATA_IN,
    output logic                  FIFO_WRITE,
    input  logic [UW-1:0]         FIFO_USE_DW,
    input  logic                  FIFO_F_FULL_N,
    output logic                  BUSY,
    output logic [PTR_W-1:0]      OWNER
);

    localparam int CNT_BITS = cnt_width(BURST);

    arb_state_t           state;
    logic [PTR_W-1:0]     ptr;
    logic [CNT_BITS-1:0]  cnt;

    logic [NREQ-1:0]      pick_onehot;
    logic [PTR_W-1:0]     pick_idx;
    logic                 pick_valid;

    logic [UW:0]          fill_sum;
    logic                 space_ok;
    logic                 ack_any;
    logic                 owner_req;
    logic                 owner_last;
    logic [WIDTH-1:0]     owner_data;
    logic                 release_now;

    rr_pick #(
        .NREQ  (NREQ),
        .PTR_W (PTR_W)
    ) u_rr_pick (
        .req         (REQ),
        .ptr         (ptr),
        .pick_onehot (pick_onehot),
        .pick_idx    (pick_idx),
        .pick_valid  (pick_valid)
    );

    // The word sitting in the output register has not reached the FIFO's
    // fill count yet, so it is added in before comparing against DEPTH.
    assign fill_sum = {1'b0, FIFO_USE_DW} + (UW + 1)'(FIFO_WRITE);
    assign space_ok = FIFO_F_FULL_N && (fill_sum < (UW + 1)'(DEPTH));

    assign owner_req  = REQ[OWNER];
    assign owner_last = REQ_LAST[OWNER];
    assign owner_data = REQ_DATA[OWNER*WIDTH +: WIDTH];

    // GNT is one-hot of the owner in GRANT and all-zero in IDLE, so masking
    // with it yields the owner's ACK bit and nothing else.
    assign ACK     = GNT & REQ & {NREQ{space_ok}};
    assign ack_any = |ACK;

    assign release_now = !owner_req ||
                         (ack_any && (owner_last || cnt == CNT_BITS'(BURST - 1)));

    always_ff @(posedge CLOCK) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (RESET) begin
            state        <= IDLE;
            ptr          <= '0;
            cnt          <= '0;
            GNT          <= '0;
            BUSY         <= 1'b0;
            OWNER        <= '0;
            FIFO_WRITE   <= 1'b0;
            FIFO_DATA_IN <= '0;
        end else begin
            // Strobe for one cycle per accepted word; data holds otherwise.
            FIFO_WRITE <= 1'b0;

            if (state == IDLE) begin
                if (pick_valid) begin
                    state <= GRANT;
                    GNT   <= pick_onehot;
                    OWNER <= pick_idx;
                    BUSY  <= 1'b1;
                    cnt   <= '0;
                end
            end else begin
                if (ack_any) begin
                    FIFO_WRITE   <= 1'b1;
                    FIFO_DATA_IN <= owner_data;
                    cnt          <= cnt + 1'b1;
                end
                if (release_now) begin
                    state <= IDLE;
                    GNT   <= '0;
                    BUSY  <= 1'b0;
                    OWNER <= '0;
                    ptr   <= PTR_W'(rr_next(int'(OWNER), NREQ));
                end
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Self-checking bench for fifo_wr_arbiter (NREQ=4, WIDTH=8, DEPTH=32,
//   BURST=4): directed scenarios plus a randomized run against a reference
//   model of the arbitration rules.
// -----------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

    localparam int WIDTH = 8;
    localparam int DEPTH = 32;
    localparam int NREQ  = 4;
    localparam int BURST = 4;
    localparam int UW    = $clog2(DEPTH) + 1;

    logic                  CLOCK = 1'b0;
    logic                  RESET;
    logic [NREQ-1:0]       REQ;
    logic [NREQ*WIDTH-1:0] REQ_DATA;
    logic [NREQ-1:0]       REQ_LAST;
    logic [NREQ-1:0]       GNT;
    logic [NREQ-1:0]       ACK;
    logic [WIDTH-1:0]      FIFO_DATA_IN;
    logic                  FIFO_WRITE;
    logic [UW-1:0]         FIFO_USE_DW;
    logic                  FIFO_F_FULL_N;
    logic                  BUSY;
    logic [1:0]            OWNER;

    int n_vec = 0;
    int n_err = 0;

    fifo_wr_arbiter #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .NREQ  (NREQ),
        .BURST (BURST)
    ) dut (
        .CLOCK         (CLOCK),
        .RESET         (RESET),
        .REQ           (REQ),
        .REQ_DATA      (REQ_DATA),
        .REQ_LAST      (REQ_LAST),
        .GNT           (GNT),
        .ACK           (ACK),
        .FIFO_DATA_IN  (FIFO_DATA_IN),
        .FIFO_WRITE    (FIFO_WRITE),
        .FIFO_USE_DW   (FIFO_USE_DW),
        .FIFO_F_FULL_N (FIFO_F_FULL_N),
        .BUSY          (BUSY),
        .OWNER         (OWNER)
    );

    always #5 CLOCK = ~CLOCK;

    // Advance past the next rising edge; registered outputs are stable here.
    task automatic tick();
        @(posedge CLOCK);
        #1;
    endtask

    // Let combinational ACK follow freshly driven inputs.
    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        RESET         = 1'b1;
        REQ           = '0;
        REQ_LAST      = '0;
        FIFO_USE_DW   = '0;
        FIFO_F_FULL_N = 1'b1;
        tick();
        RESET = 1'b0;
    endtask

    // ------------------------------------------------------------------
    // Reference model: owner (-1 = nobody), priority pointer, beats taken,
    // and the registered FIFO write stage.
    // ------------------------------------------------------------------
    int         m_owner;
    int         m_ptr;
    int         m_cnt;
    bit         m_wr;
    logic [7:0] m_data;

    task automatic model_clear();
        m_owner = -1;
        m_ptr   = 0;
        m_cnt   = 0;
        m_wr    = 1'b0;
        m_data  = '0;
    endtask

    function automatic logic [NREQ-1:0] model_ack();
        int fill;
        fill = int'(FIFO_USE_DW) + int'(m_wr);
        if (m_owner < 0) return '0;
        if (REQ[m_owner] && FIFO_F_FULL_N && fill < DEPTH) return NREQ'(1 << m_owner);
        return '0;
    endfunction

    task automatic model_step();
        logic [NREQ-1:0] a;
        bit              rel;
        int              cand;
        a = model_ack();
        if (RESET) begin
            model_clear();
        end else if (m_owner < 0) begin
            m_wr = 1'b0;
            for (int k = 0; k < NREQ; k++) begin
                cand = (m_ptr + k) % NREQ;
                if (m_owner < 0 && REQ[cand]) begin
                    m_owner = cand;
                    m_cnt   = 0;
                end
            end
        end else begin
            m_wr = (a != 0);
            rel  = !REQ[m_owner] || (m_wr && (REQ_LAST[m_owner] || m_cnt == BURST - 1));
            if (m_wr) begin
                m_data = REQ_DATA[m_owner*WIDTH +: WIDTH];
                m_cnt++;
            end
            if (rel) begin
                m_ptr   = (m_owner + 1) % NREQ;
                m_owner = -1;
            end
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        RESET         = 1'b1;
        REQ           = 4'b1111;
        REQ_LAST      = '0;
        REQ_DATA      = 32'h44332211;
        FIFO_USE_DW   = '0;
        FIFO_F_FULL_N = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            n_vec++;
            if ({GNT, ACK, FIFO_WRITE, FIFO_DATA_IN, BUSY, OWNER} !== 20'h0) begin
                n_err++;
                $display("FAIL reset_outputs cycle %0d: got gnt=%b ack=%b wr=%b din=%h busy=%b owner=%0d, want all 0",
                         c, GNT, ACK, FIFO_WRITE, FIFO_DATA_IN, BUSY, OWNER);
            end
        end
        RESET = 1'b0;
        settle();
        n_vec++;
        if (GNT !== 4'b0000) begin
            n_err++;
            $display("FAIL reset_release_idle: gnt=%b want 0000", GNT);
        end
        tick();
        n_vec++;
        if (GNT !== 4'b0001 || BUSY !== 1'b1 || OWNER !== 2'd0) begin
            n_err++;
            $display("FAIL reset_first_grant: gnt=%b busy=%b owner=%0d want 0001/1/0", GNT, BUSY, OWNER);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_single_packet();
        logic [7:0] w;
        do_reset();
        REQ      = 4'b0010;
        REQ_LAST = 4'b0000;
        REQ_DATA = '0;
        REQ_DATA[15:8] = 8'hA1;
        settle();
        n_vec++;
        if (ACK !== 4'b0000) begin
            n_err++;
            $display("FAIL single_idle_ack: ack=%b want 0000", ACK);
        end
        tick();
        n_vec++;
        if (GNT !== 4'b0010 || OWNER !== 2'd1 || BUSY !== 1'b1) begin
            n_err++;
            $display("FAIL single_grant: gnt=%b owner=%0d busy=%b want 0010/1/1", GNT, OWNER, BUSY);
        end
        for (int k = 0; k < 3; k++) begin
            w = 8'hA1 + 8'(k);
            REQ_DATA[15:8] = w;
            REQ_LAST       = (k == 2) ? 4'b0010 : 4'b0000;
            settle();
            n_vec++;
            if (ACK !== 4'b0010) begin
                n_err++;
                $display("FAIL single_ack beat %0d: ack=%b want 0010", k, ACK);
            end
            n_vec++;
            if (FIFO_WRITE !== (k > 0) || (k > 0 && FIFO_DATA_IN !== w - 8'd1)) begin
                n_err++;
                $display("FAIL single_write beat %0d: wr=%b din=%h want wr=%b din=%h",
                         k, FIFO_WRITE, FIFO_DATA_IN, (k > 0), w - 8'd1);
            end
            tick();
        end
        REQ      = 4'b0000;
        REQ_LAST = 4'b0000;
        settle();
        n_vec++;
        if (FIFO_WRITE !== 1'b1 || FIFO_DATA_IN !== 8'hA3 || GNT !== 4'b0000 || BUSY !== 1'b0 || OWNER !== 2'd0) begin
            n_err++;
            $display("FAIL single_release: wr=%b din=%h gnt=%b busy=%b owner=%0d want 1/a3/0000/0/0",
                     FIFO_WRITE, FIFO_DATA_IN, GNT, BUSY, OWNER);
        end
        REQ = 4'b1111;
        tick();
        n_vec++;
        if (GNT !== 4'b0100 || FIFO_WRITE !== 1'b0 || FIFO_DATA_IN !== 8'hA3) begin
            n_err++;
            $display("FAIL single_ptr_next: gnt=%b wr=%b din=%h want 0100/0/a3", GNT, FIFO_WRITE, FIFO_DATA_IN);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_round_robin();
        logic [3:0] want_ack;
        logic [3:0] prev_ack;
        int         writes;
        do_reset();
        REQ      = 4'b1111;
        REQ_LAST = 4'b0000;
        REQ_DATA = 32'hD3C2B1A0;
        prev_ack = '0;
        writes   = 0;
        for (int c = 0; c < 25; c++) begin
            settle();
            want_ack = (c % 5 == 0) ? 4'b0000 : 4'(1 << ((c / 5) % 4));
            n_vec++;
            if (ACK !== want_ack || FIFO_WRITE !== (prev_ack != 0)) begin
                n_err++;
                $display("FAIL rr_cycle %0d: ack=%b wr=%b want ack=%b wr=%b",
                         c, ACK, FIFO_WRITE, want_ack, (prev_ack != 0));
            end
            if (c <= 20 && FIFO_WRITE === 1'b1) writes++;
            prev_ack = want_ack;
            tick();
        end
        n_vec++;
        if (writes != 16) begin
            n_err++;
            $display("FAIL rr_throughput: %0d writes in 20 cycles, want 16", writes);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_full();
        do_reset();
        REQ         = 4'b0001;
        REQ_DATA    = 32'h0000005A;
        FIFO_USE_DW = 6'd31;
        tick();
        settle();
        n_vec++;
        if (ACK !== 4'b0001) begin
            n_err++;
            $display("FAIL full_last_slot: ack=%b want 0001", ACK);
        end
        tick();
        settle();
        n_vec++;
        if (ACK !== 4'b0000 || GNT !== 4'b0001 || FIFO_WRITE !== 1'b1) begin
            n_err++;
            $display("FAIL full_inflight: ack=%b gnt=%b wr=%b want 0000/0001/1", ACK, GNT, FIFO_WRITE);
        end
        tick();
        FIFO_F_FULL_N = 1'b0;
        settle();
        n_vec++;
        if (ACK !== 4'b0000 || GNT !== 4'b0001) begin
            n_err++;
            $display("FAIL full_flag: ack=%b gnt=%b want 0000/0001", ACK, GNT);
        end
        tick();
        FIFO_USE_DW   = 6'd20;
        FIFO_F_FULL_N = 1'b1;
        settle();
        n_vec++;
        if (ACK !== 4'b0001 || GNT !== 4'b0001) begin
            n_err++;
            $display("FAIL full_resume: ack=%b gnt=%b want 0001/0001", ACK, GNT);
        end
        tick();
        FIFO_USE_DW = '0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_abandon();
        do_reset();
        REQ = 4'b0100;
        tick();
        for (int k = 0; k < 2; k++) begin
            settle();
            n_vec++;
            if (ACK !== 4'b0100) begin
                n_err++;
                $display("FAIL abandon_ack beat %0d: ack=%b want 0100", k, ACK);
            end
            tick();
        end
        REQ = 4'b1011;
        settle();
        n_vec++;
        if (ACK !== 4'b0000 || GNT !== 4'b0100) begin
            n_err++;
            $display("FAIL abandon_drop: ack=%b gnt=%b want 0000/0100", ACK, GNT);
        end
        tick();
        n_vec++;
        if (GNT !== 4'b0000 || BUSY !== 1'b0) begin
            n_err++;
            $display("FAIL abandon_release: gnt=%b busy=%b want 0000/0", GNT, BUSY);
        end
        tick();
        n_vec++;
        if (GNT !== 4'b1000 || OWNER !== 2'd3) begin
            n_err++;
            $display("FAIL abandon_next: gnt=%b owner=%0d want 1000/3", GNT, OWNER);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_burst();
        do_reset();
        // Leave ptr at 3 so a reset that fails to clear it is visible.
        REQ      = 4'b0100;
        REQ_LAST = 4'b0100;
        tick();
        tick();
        REQ      = 4'b0010;
        REQ_LAST = 4'b0000;
        REQ_DATA = 32'h00007700;
        tick();
        tick();
        n_vec++;
        if (FIFO_WRITE !== 1'b1 || GNT !== 4'b0010) begin
            n_err++;
            $display("FAIL midreset_setup: wr=%b gnt=%b want 1/0010", FIFO_WRITE, GNT);
        end
        RESET = 1'b1;
        REQ   = 4'b1011;
        tick();
        n_vec++;
        if ({GNT, ACK, FIFO_WRITE, FIFO_DATA_IN, BUSY, OWNER} !== 20'h0) begin
            n_err++;
            $display("FAIL midreset_outputs: gnt=%b ack=%b wr=%b din=%h busy=%b owner=%0d want all 0",
                     GNT, ACK, FIFO_WRITE, FIFO_DATA_IN, BUSY, OWNER);
        end
        RESET = 1'b0;
        tick();
        n_vec++;
        if (GNT !== 4'b0001 || OWNER !== 2'd0) begin
            n_err++;
            $display("FAIL midreset_regrant: gnt=%b owner=%0d want 0001/0", GNT, OWNER);
        end
    endtask

    // ------------------------------------------------------------------
    task automatic test_random();
        logic [NREQ-1:0] a;
        logic [19:0]     got;
        logic [19:0]     want;
        logic [3:0]      want_gnt;
        logic [1:0]      want_owner;
        do_reset();
        model_clear();
        a = '0;
        for (int c = 0; c < 1500; c++) begin
            RESET = ($urandom_range(0, 99) == 0);
            // Producers mostly hold a pending word until it is accepted.
            for (int i = 0; i < NREQ; i++) begin
                if (!(REQ[i] && !a[i] && $urandom_range(0, 7) != 0)) begin
                    REQ[i]                  = $urandom_range(0, 1);
                    REQ_DATA[i*WIDTH +: WIDTH] = 8'($urandom);
                    REQ_LAST[i]             = ($urandom_range(0, 2) == 0);
                end
            end
            FIFO_USE_DW   = ($urandom_range(0, 1) == 0) ? UW'($urandom_range(0, 10))
                                                        : UW'($urandom_range(28, 32));
            FIFO_F_FULL_N = ($urandom_range(0, 9) != 0);
            settle();
            a          = model_ack();
            want_gnt   = (m_owner < 0) ? 4'b0000 : 4'(1 << m_owner);
            want_owner = (m_owner < 0) ? 2'd0 : 2'(m_owner);
            want = {want_gnt, a, m_wr, m_data, (m_owner >= 0), want_owner};
            got  = {GNT, ACK, FIFO_WRITE, FIFO_DATA_IN, BUSY, OWNER};
            n_vec++;
            if (got !== want) begin
                n_err++;
                $display("FAIL random cycle %0d: got gnt=%b ack=%b wr=%b din=%h busy=%b owner=%0d want gnt=%b ack=%b wr=%b din=%h busy=%b owner=%0d",
                         c, GNT, ACK, FIFO_WRITE, FIFO_DATA_IN, BUSY, OWNER,
                         want_gnt, a, m_wr, m_data, (m_owner >= 0), want_owner);
            end
            model_step();
            tick();
        end
        RESET = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_packet();
        test_round_robin();
        test_full();
        test_abandon();
        test_reset_mid_burst();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin write-port arbiter that shares the write side of one FIFO among NREQ producers.
- Grants one producer at a time, for up to BURST words or until it flags the end of its packet.
- Throttles writes using the FIFO fill count and the active-low full flag.
- Drives the FIFO's DATA_IN/WRITE pins from a registered stage.

Parameters:
- WIDTH, 8, data word width.
- DEPTH, 32, FIFO depth in words.
- NREQ, 4, number of producers (2..16).
- BURST, 4, maximum words per grant before forced rotation (1..DEPTH).

Ports:
- CLOCK  in  1  rising-edge clock.
- RESET  in  1  synchronous reset, active high.
- REQ  in  NREQ  producer i has a valid word on its data slice.
- REQ_DATA  in  NREQ*WIDTH  producer words; slice i is bits [i*WIDTH +: WIDTH].
- REQ_LAST  in  NREQ  current word of producer i ends its packet.
- GNT  out  NREQ  one-hot grant, registered.
- ACK  out  NREQ  word of producer i accepted this cycle; combinational.
- FIFO_DATA_IN  out  WIDTH  to FIFO DATA_IN; registered.
- FIFO_WRITE  out  1  to FIFO WRITE; registered.
- FIFO_USE_DW  in  $clog2(DEPTH)+1  FIFO fill count.
- FIFO_F_FULL_N  in  1  FIFO full flag, active low.
- BUSY  out  1  a grant is held.
- OWNER  out  $clog2(NREQ) (min 1)  index of the granted producer, 0 when idle.

Behaviour:
- Reset (RESET=1 at a clock edge):
  - GNT=0, ACK=0, FIFO_WRITE=0, FIFO_DATA_IN=0, BUSY=0, OWNER=0.
  - State IDLE, priority pointer ptr=0, beat counter cnt=0.
  - A registered write in flight is dropped.
- Space check: space_ok = FIFO_F_FULL_N && (FIFO_USE_DW + FIFO_WRITE) < DEPTH.
  - The FIFO_WRITE term accounts for the one write still in flight in the output register.
  - Compute it in width $clog2(DEPTH)+2 so it cannot overflow.
- State IDLE:
  - If |REQ, pick the first requester at or after ptr, cyclically (ptr has highest priority).
  - Next cycle: GNT=onehot(pick), OWNER=pick, BUSY=1, cnt=0, state GRANT.
  - If REQ==0, stay in IDLE.
- State GRANT (owner o):
  - ACK[o] = REQ[o] && space_ok; every other ACK bit is 0.
  - On ACK[o]: next edge FIFO_WRITE=1, FIFO_DATA_IN=REQ_DATA slice o, cnt=cnt+1.
  - Otherwise FIFO_WRITE=0 on the next edge, and FIFO_DATA_IN holds its previous value.
  - Release to IDLE when any of the following holds:
    - ACK[o] && REQ_LAST[o];
    - ACK[o] && cnt==BURST-1;
    - REQ[o]==0 (the producer abandons its grant).
  - On release: GNT=0, BUSY=0, OWNER=0, ptr=(o+1) mod NREQ.
- Latency:
  - REQ to GNT takes 1 cycle; ACK is valid in the GRANT cycle.
  - ACK to FIFO_WRITE takes 1 cycle.
  - Every release costs exactly one IDLE cycle, even when other requests are pending.
- Full FIFO: ACK stays 0 and GNT is held; there is no timeout. The producer keeps REQ, REQ_DATA and REQ_LAST stable until it sees ACK.
- Simultaneous requests: only the owner's REQ is examined in GRANT; REQ changes from other producers take effect at the next IDLE.
- A single word with REQ_LAST=1 gives a one-beat grant.
- If BURST=1, every accepted word causes a release.
- ptr wraps from NREQ-1 to 0.

Decomposition:
- Package fifo_arb_pkg holds:
  - typedef enum logic {IDLE, GRANT} arb_state_t;
  - the function rr_next(ptr, n) used for the pointer update;
  - the constant CNT_W = $clog2(BURST)+1.
- Sub-module rr_pick (parameter NREQ):
  - Inputs: REQ vector and ptr.
  - Outputs: one-hot pick, its index, and a valid flag.
  - Purely combinational, implemented as a double-width rotate and priority encode.

Test Plan (NREQ=4, WIDTH=8, DEPTH=32, BURST=4):
1. RESET=1 for 2 cycles with REQ=4'b1111 -> all outputs 0 during reset. First GNT after release is 4'b0001, one cycle later.
2. Only REQ[1], words 0xA1,0xA2,0xA3, LAST on 0xA3, FIFO_USE_DW=0 -> GNT=4'b0010 one cycle after REQ, ACK[1] high 3 consecutive cycles. FIFO_WRITE high 3 cycles, 1 cycle behind ACK, with data A1,A2,A3. BUSY falls and ptr becomes 2.
3. REQ=4'b1111 held, LAST never asserted -> owners 0,1,2,3,0 in order, 4 ACKs each, 1 IDLE cycle between grants; 16 words in 20 cycles.
4. FIFO_USE_DW=31, FIFO_WRITE=0, owner 0 -> one ACK. Next cycle (USE_DW still 31, FIFO_WRITE=1) -> ACK=0 and GNT held. Then FIFO_F_FULL_N=0 -> ACK stays 0. Then USE_DW=20 and F_FULL_N=1 -> ACK resumes.
5. Owner 2 drops REQ after 2 accepted words -> GNT=0 next cycle, ptr=3, REQ[3] granted next.
6. RESET pulsed 1 cycle while owner 1 is mid-burst with FIFO_WRITE=1 -> next cycle all outputs 0 and ptr=0; after reset, re-arbitration grants producer 0 first if it is requesting.
